// File: rtl/ikaopll_bus_wrsched_if.sv
// ikaopll_bus_wrsched_if: host/stream write handshakes plus the IKAOPLL CPU-bus pins driven by the scheduler
interface ikaopll_bus_wrsched_if;
   logic       host_valid;
   logic [7:0] host_addr;
   logic [7:0] host_data;
   logic       host_ack;
   logic       strm_valid;
   logic [7:0] strm_addr;
   logic [7:0] strm_data;
   logic       strm_ack;
   logic       cs_n;
   logic       wr_n;
   logic       a0;
   logic [7:0] d;
   logic       busy;
   modport master (
      output host_valid, host_addr, host_data, strm_valid, strm_addr, strm_data,
      input  host_ack, strm_ack, cs_n, wr_n, a0, d, busy
   );
   modport slave (
      input  host_valid, host_addr, host_data, strm_valid, strm_addr, strm_data,
      output host_ack, strm_ack, cs_n, wr_n, a0, d, busy
   );
endinterface

// File: rtl/ikaopll_bus_wrsched.sv
// ikaopll_bus_wrsched: arbitrates host/stream register writes and paces them onto the IKAOPLL bus on phiM enables.
// Define IKAOPLL_WRSCHED_SHADOW_EN to add a 64x8 shadow of data written to registers 8'h00-8'h3F.
module ikaopll_bus_wrsched #(
   parameter int STB_CYC       = 2,
   parameter int ADDR_WAIT_CYC = 12,
   parameter int DATA_WAIT_CYC = 84,
   parameter int ARB_MODE      = 0
) (
   input  logic                 i_EMUCLK,
   input  logic                 i_RST,
   input  logic                 i_phiM_PCEN_n,
`ifdef IKAOPLL_WRSCHED_SHADOW_EN
   input  logic [5:0]           i_SHD_ADDR,
   output logic [7:0]           o_SHD_DATA,
`endif
   ikaopll_bus_wrsched_if.slave bus
);
   localparam int MAX_AS = STB_CYC > ADDR_WAIT_CYC ? STB_CYC : ADDR_WAIT_CYC;
   localparam int MAX_C  = MAX_AS > DATA_WAIT_CYC ? MAX_AS : DATA_WAIT_CYC;
   localparam int CW     = MAX_C > 1 ? $clog2(MAX_C) : 1;
   localparam logic [CW-1:0] STB_N = CW'(STB_CYC - 1);
   localparam logic [CW-1:0] AW_N  = CW'(ADDR_WAIT_CYC - 1);
   localparam logic [CW-1:0] DW_N  = CW'(DATA_WAIT_CYC - 1);

   typedef enum logic [2:0] {IDLE, ASTB, AWAIT, DSTB, DWAIT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    addr_q, addr_d, data_q, data_d, d_q, d_d;
   logic          rr_q, rr_d, host_ack_q, host_ack_d, strm_ack_q, strm_ack_d;
   logic          cs_n_q, cs_n_d, a0_q, a0_d, busy_q, busy_d;
   logic          can_acc, done, pick_strm, acc;

   always_comb begin
      done       = !i_phiM_PCEN_n && cnt_q == '0;
      // rr_q set means the stream wins the next tie
      pick_strm  = bus.strm_valid && (!bus.host_valid || (ARB_MODE != 0 && rr_q));
      acc        = state_q == IDLE && (bus.host_valid || bus.strm_valid) && can_acc;
      state_d    = state_q;
      cnt_d      = !i_phiM_PCEN_n && cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      rr_d       = rr_q;
      host_ack_d = 1'b0;
      strm_ack_d = 1'b0;
      if (acc) begin
         state_d    = ASTB;
         cnt_d      = STB_N;
         addr_d     = pick_strm ? bus.strm_addr : bus.host_addr;
         data_d     = pick_strm ? bus.strm_data : bus.host_data;
         rr_d       = !pick_strm;
         host_ack_d = !pick_strm;
         strm_ack_d = pick_strm;
      end else if (state_q != IDLE && done) begin
         state_d = state_q == ASTB ? AWAIT : state_q == AWAIT ? DSTB : state_q == DSTB ? DWAIT : IDLE;
         cnt_d   = state_q == ASTB ? AW_N : state_q == AWAIT ? STB_N : state_q == DSTB ? DW_N : '0;
      end
      cs_n_d = !(state_d == ASTB || state_d == DSTB);
      a0_d   = state_d == ASTB ? 1'b0 : state_d == DSTB ? 1'b1 : a0_q;
      d_d    = state_d == ASTB ? addr_d : state_d == DSTB ? data_d : d_q;
      busy_d = state_d != IDLE;
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         rr_q       <= 1'b0;
         host_ack_q <= 1'b0;
         strm_ack_q <= 1'b0;
         cs_n_q     <= 1'b1;
         a0_q       <= 1'b0;
         d_q        <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         rr_q       <= rr_d;
         host_ack_q <= host_ack_d;
         strm_ack_q <= strm_ack_d;
         cs_n_q     <= cs_n_d;
         a0_q       <= a0_d;
         d_q        <= d_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.host_ack = host_ack_q;
   assign bus.strm_ack = strm_ack_q;
   assign bus.cs_n     = cs_n_q;
   assign bus.wr_n     = cs_n_q;
   assign bus.a0       = a0_q;
   assign bus.d        = d_q;
   assign bus.busy     = busy_q;

`ifdef IKAOPLL_WRSCHED_SHADOW_EN
   logic       clr_q, clr_d;
   logic [5:0] clr_idx_q, clr_idx_d;
   logic [7:0] shd_q, shd_d;
   logic [7:0] shd_mem [64];

   always_comb begin
      clr_d     = clr_q && clr_idx_q != 6'd63;
      clr_idx_d = clr_q ? clr_idx_q + 6'd1 : clr_idx_q;
      shd_d     = clr_q ? 8'h00 : shd_mem[i_SHD_ADDR];
   end

   always_ff @(posedge i_EMUCLK) begin
      if (i_RST) begin
         clr_q     <= 1'b1;
         clr_idx_q <= '0;
         shd_q     <= '0;
      end else begin
         clr_q     <= clr_d;
         clr_idx_q <= clr_idx_d;
         shd_q     <= shd_d;
      end
   end

   // one entry cleared per clock; a write dropped by reset never reaches the shadow
   always_ff @(posedge i_EMUCLK) begin
      if (clr_q) shd_mem[clr_idx_q] <= 8'h00;
      else if (!i_RST && state_q == DSTB && done && addr_q < 8'h40) shd_mem[addr_q[5:0]] <= data_q;
   end

   assign can_acc    = !clr_q;
   assign o_SHD_DATA = shd_q;
`else
   assign can_acc = 1'b1;
`endif
endmodule

// File: tb/tb_ikaopll_bus_wrsched.sv
// tb_ikaopll_bus_wrsched: random host/stream traffic on three scheduler configurations, checked per clock against
// a transaction model that places phase boundaries by counting phiM enables.
module tb_ikaopll_bus_wrsched;
   localparam int NE = 8000, REQ_END = 6500, RST_FROM = 2000;
`ifdef IKAOPLL_WRSCHED_SHADOW_EN
   localparam int CLR = 64;
`else
   localparam int CLR = 0;
`endif
   localparam int STBS [3] = '{2, 2, 1};
   localparam int AWS  [3] = '{12, 12, 1};
   localparam int DWS  [3] = '{84, 84, 1};
   localparam int ARBS [3] = '{0, 1, 0};

   logic        clk = 1'b0, rst = 1'b1, phi_n = 1'b0;
   logic        hv [3], sv [3];
   logic [7:0]  ha [3], hd [3], sa [3], sd [3];
   logic [12:0] obs [3];
`ifdef IKAOPLL_WRSCHED_SHADOW_EN
   logic [5:0]  shd_addr = '0;
   logic [7:0]  shd_data [3];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : u
      ikaopll_bus_wrsched_if bif ();
      assign bif.host_valid = hv[g];
      assign bif.host_addr  = ha[g];
      assign bif.host_data  = hd[g];
      assign bif.strm_valid = sv[g];
      assign bif.strm_addr  = sa[g];
      assign bif.strm_data  = sd[g];
      assign obs[g] = {bif.cs_n, bif.wr_n, bif.a0, bif.d, bif.busy, bif.host_ack, bif.strm_ack};
      ikaopll_bus_wrsched #(
         .STB_CYC(STBS[g]), .ADDR_WAIT_CYC(AWS[g]), .DATA_WAIT_CYC(DWS[g]), .ARB_MODE(ARBS[g])
      ) dut (
         .i_EMUCLK(clk),
         .i_RST(rst),
         .i_phiM_PCEN_n(phi_n),
`ifdef IKAOPLL_WRSCHED_SHADOW_EN
         .i_SHD_ADDR(shd_addr),
         .o_SHD_DATA(shd_data[g]),
`endif
         .bus(bif)
      );
   end

   bit          en_arr [NE + 1];
   logic [12:0] expv [3][NE + 1];
   logic [12:0] idlev [3];
   int          lastf [3], free_e [3];
   bit          rrs [3];
   logic [7:0]  qa [3][2][16], qd [3][2][16];
   int          qh [3][2], qn [3][2];
   logic [7:0]  mshd [3][64];
   bit          pend [3];
   int          pend_e [3];
   logic [7:0]  pend_a [3], pend_d [3];
   int          n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got %h want %h", tag, got, want);
      end
   endtask

   task automatic push(input int d, input int s, input logic [7:0] a, input logic [7:0] dt);
      if (qn[d][s] < 16) begin
         qa[d][s][(qh[d][s] + qn[d][s]) % 16] = a;
         qd[d][s][(qh[d][s] + qn[d][s]) % 16] = dt;
         qn[d][s]++;
      end
   endtask

   // edge on which the cnt-th enable strictly after edge t arrives
   function automatic int after(input int t, input int cnt);
      int c = 0;
      for (int j = t + 1; j <= NE; j++) if (en_arr[j]) begin
         c++;
         if (c == cnt) return j;
      end
      return NE;
   endfunction

   task automatic step(input int d, input int n);
      bit         ps;
      int         e1, e2, e3, e4;
      logic [7:0] a, dt;
      if (n < REQ_END) for (int s = 0; s < 2; s++)
         if ($urandom_range(15) == 0 && qn[d][s] < 4) push(d, s, 8'($urandom), 8'($urandom));
      hv[d] = qn[d][0] != 0;
      ha[d] = qa[d][0][qh[d][0]];
      hd[d] = qd[d][0][qh[d][0]];
      sv[d] = qn[d][1] != 0;
      sa[d] = qa[d][1][qh[d][1]];
      sd[d] = qd[d][1][qh[d][1]];
      if (rst) begin
         lastf[d]  = n - 1;
         idlev[d]  = {3'b110, 8'h00, 3'b000};
         free_e[d] = n + 1 + CLR;
         rrs[d]    = 1'b0;
         pend[d]   = 1'b0;
         for (int i = 0; i < 64; i++) mshd[d][i] = 8'h00;
      end else if (n >= free_e[d] && (hv[d] || sv[d])) begin
         ps = sv[d] && (!hv[d] || (ARBS[d] != 0 && rrs[d]));
         rrs[d] = !ps;
         a  = ps ? sa[d] : ha[d];
         dt = ps ? sd[d] : hd[d];
         e1 = after(n, STBS[d]);
         e2 = after(e1, AWS[d]);
         e3 = after(e2, STBS[d]);
         e4 = after(e3, DWS[d]);
         for (int j = n; j < e4; j++)
            expv[d][j] = j < e1 ? {3'b000, a, 3'b100} : j < e2 ? {3'b110, a, 3'b100} :
                         j < e3 ? {3'b001, dt, 3'b100} : {3'b111, dt, 3'b100};
         expv[d][n][1:0] = ps ? 2'b01 : 2'b10;
         lastf[d]  = e4 - 1;
         idlev[d]  = {3'b111, dt, 3'b000};
         free_e[d] = e4 + 1;
         if (a < 8'h40) begin
            pend[d]   = 1'b1;
            pend_e[d] = e3;
            pend_a[d] = a;
            pend_d[d] = dt;
         end
         qh[d][ps] = (qh[d][ps] + 1) % 16;
         qn[d][ps]--;
      end
   endtask

   initial begin
      int rst_at = 0;
      for (int n = 0; n <= NE; n++) begin
         int m = (n / 600) % 4;
         en_arr[n] = n < 1000 || n >= REQ_END ? 1'b1 : m == 0 ? 1'b1 : m == 1 ? n % 4 == 0 :
                     m == 2 ? $urandom_range(1) == 1 : $urandom_range(7) != 0;
      end
      for (int d = 0; d < 3; d++) begin
         qh[d] = '{0, 0};
         qn[d] = '{0, 0};
         lastf[d] = 0;
         push(d, 0, 8'h10, 8'h5A);
         push(d, 0, 8'h20, 8'h1F);
         push(d, 1, 8'h40, 8'h33);
         push(d, 1, 8'h3A, 8'hC6);
      end
      for (int n = 1; n <= NE - 200; n++) begin
         if (rst_at == 0 && n >= RST_FROM && n - 1 <= lastf[0] && expv[0][n - 1][12:10] == 3'b110 && expv[0][n - 1][2])
            rst_at = n;
         rst   = n <= 2 || n == rst_at;
         phi_n = !en_arr[n];
         for (int d = 0; d < 3; d++) step(d, n);
         @(posedge clk);
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("bus%0d@%0d", d, n), obs[d], n <= lastf[d] ? expv[d][n] : idlev[d]);
            if (pend[d] && pend_e[d] == n) begin
               mshd[d][pend_a[d][5:0]] = pend_d[d];
               pend[d] = 1'b0;
            end
         end
      end
`ifdef IKAOPLL_WRSCHED_SHADOW_EN
      for (int i = 0; i < 64; i++) begin
         shd_addr = 6'(i);
         @(posedge clk);
         @(negedge clk);
         for (int d = 0; d < 3; d++)
            chk($sformatf("shd%0d[%0d]", d, i), {5'b0, shd_data[d]}, {5'b0, mshd[d][i]});
      end
`endif
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
